// File: rtl/boardman_cobs_pkg.sv
// rtl/boardman_cobs_pkg.sv - COBS framing constants and deframer state encoding
// Shared between the RX deframer and the TX-side COBS encoder.
package boardman_cobs_pkg;

    localparam logic [7:0] COBS_DELIM    = 8'h00;
    localparam logic [7:0] COBS_CODE_MAX = 8'hFF;
    localparam int         COBS_STATE_W  = 2;

    typedef enum logic [COBS_STATE_W-1:0] {
        ST_SOF  = 2'd0,
        ST_DATA = 2'd1,
        ST_GAP  = 2'd2,
        ST_DROP = 2'd3
    } cobs_state_t;

endpackage

// File: rtl/boardman_axis_out_reg.sv
// rtl/boardman_axis_out_reg.sv - single-beat AXIS output register carrying data, last and user
// A push is only issued when the register is empty or being drained this cycle.
module boardman_axis_out_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       push_last,
    input  logic       push_user,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser
);

    logic [9:0] beat_q;
    logic       valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q  <= '0;
            valid_q <= 1'b0;
        end else if (push) begin
            beat_q  <= {push_data, push_last, push_user};
            valid_q <= 1'b1;
        end else if (m_axis_tready) begin
            valid_q <= 1'b0;
        end
    end

    assign m_axis_tdata  = beat_q[9:2];
    assign m_axis_tlast  = beat_q[1];
    assign m_axis_tuser  = beat_q[0];
    assign m_axis_tvalid = valid_q;

endmodule

// File: rtl/boardman_cobs_rx_deframer.sv
// rtl/boardman_cobs_rx_deframer.sv - COBS frame decoder from UART RX bytes to an AXIS packet stream
// Optional per-frame length limit enabled by BOARDMAN_COBS_MAXLEN_EN.
module boardman_cobs_rx_deframer
    import boardman_cobs_pkg::*;
`ifdef BOARDMAN_COBS_MAXLEN_EN
#(
    parameter int MAX_LEN = 255
)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser
);

    cobs_state_t state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        zpend_q, zpend_d;
    logic        hold_valid_q, hold_valid_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic        hold_err_q, hold_err_d;
`ifdef BOARDMAN_COBS_MAXLEN_EN
    logic [8:0]  len_q, len_d;
`endif

    logic       accept, is_delim;
    logic       load, emit, end_normal, end_error;
    logic [7:0] emit_data;
    logic       push, push_last, push_user;
    logic [7:0] push_data;

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign is_delim      = (s_axis_tdata == COBS_DELIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SOF;
            cnt_q        <= '0;
            zpend_q      <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_err_q   <= 1'b0;
`ifdef BOARDMAN_COBS_MAXLEN_EN
            len_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            zpend_q      <= zpend_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_err_q   <= hold_err_d;
`ifdef BOARDMAN_COBS_MAXLEN_EN
            len_q        <= len_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        zpend_d      = zpend_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_err_d   = hold_err_q;
`ifdef BOARDMAN_COBS_MAXLEN_EN
        len_d        = len_q;
`endif
        load       = 1'b0;
        emit       = 1'b0;
        emit_data  = s_axis_tdata;
        end_normal = 1'b0;
        end_error  = 1'b0;
        push       = 1'b0;
        push_data  = hold_data_q;
        push_last  = 1'b0;
        push_user  = 1'b0;

        if (accept) begin
            case (state_q)
                ST_SOF:  load = !is_delim;
                ST_DATA: begin
                    if (is_delim) begin
                        end_error = 1'b1;
                    end else begin
                        emit  = 1'b1;
                        cnt_d = cnt_q - 8'd1;
                        if (cnt_q == 8'd1) state_d = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (is_delim) begin
                        end_normal = 1'b1;
                    end else begin
                        load      = 1'b1;
                        emit      = zpend_q;
                        emit_data = COBS_DELIM;
                    end
                end
`ifdef BOARDMAN_COBS_MAXLEN_EN
                ST_DROP: end_error = is_delim;
`endif
                default: state_d = ST_SOF;
            endcase
        end

        if (load) begin
            cnt_d   = s_axis_tdata - 8'd1;
            zpend_d = (s_axis_tdata != COBS_CODE_MAX);
            state_d = (s_axis_tdata == 8'd1) ? ST_GAP : ST_DATA;
        end

        // A new decoded byte displaces the held one into the output register.
        if (emit) begin
`ifdef BOARDMAN_COBS_MAXLEN_EN
            if (len_q == 9'(MAX_LEN)) begin
                hold_err_d = 1'b1;
                state_d    = ST_DROP;
            end else begin
                len_d = len_q + 9'd1;
`endif
                push         = hold_valid_q;
                hold_valid_d = 1'b1;
                hold_data_d  = emit_data;
`ifdef BOARDMAN_COBS_MAXLEN_EN
            end
`endif
        end

        if (end_normal || end_error) begin
            push         = hold_valid_q || end_error;
            push_data    = hold_valid_q ? hold_data_q : COBS_DELIM;
            push_last    = 1'b1;
            push_user    = end_error || hold_err_q;
            hold_valid_d = 1'b0;
            hold_err_d   = 1'b0;
            cnt_d        = '0;
            zpend_d      = 1'b0;
            state_d      = ST_SOF;
`ifdef BOARDMAN_COBS_MAXLEN_EN
            len_d        = '0;
`endif
        end
    end

    boardman_axis_out_reg u_out_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .push          (push),
        .push_data     (push_data),
        .push_last     (push_last),
        .push_user     (push_user),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
    );

endmodule

// File: tb/tb_boardman_cobs_rx_deframer.sv
// tb/tb_boardman_cobs_rx_deframer.sv - scoreboard bench for the COBS RX deframer
// Expected beats are queued by the stimulus and checked by an independent monitor.
module tb_boardman_cobs_rx_deframer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_axis_tdata = '0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       m_axis_tlast;
    logic       m_axis_tuser;

    int vectors = 0;
    int miscompares = 0;

    logic [9:0] exp_q[$];
    logic [9:0] exp_beat;
    logic [9:0] stall_beat;
    logic       stalled = 1'b0;
    logic       hs = 1'b0;
    logic       rand_rdy = 1'b0;

    always #5 clk = ~clk;

`ifdef BOARDMAN_COBS_MAXLEN_EN
    boardman_cobs_rx_deframer #(.MAX_LEN(4)) dut (
`else
    boardman_cobs_rx_deframer dut (
`endif
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
    );

    function automatic logic [9:0] beat(input logic [7:0] d, input logic l, input logic u);
        return {d, l, u};
    endfunction

    always @(posedge clk) hs <= s_axis_tvalid && s_axis_tready;

    always @(posedge clk) begin
        #2;
        m_axis_tready = rand_rdy ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                vectors++;
                if (!m_axis_tvalid || {m_axis_tdata, m_axis_tlast, m_axis_tuser} != stall_beat) begin
                    miscompares++;
                    $display("FAIL stall_hold: got valid=%0b beat=%h required valid=1 beat=%h",
                             m_axis_tvalid, {m_axis_tdata, m_axis_tlast, m_axis_tuser}, stall_beat);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                vectors++;
                stalled = 1'b0;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat: got data=%h last=%0b user=%0b required none",
                             m_axis_tdata, m_axis_tlast, m_axis_tuser);
                end else begin
                    exp_beat = exp_q.pop_front();
                    if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} != exp_beat) begin
                        miscompares++;
                        $display("FAIL beat: got data=%h last=%0b user=%0b required data=%h last=%0b user=%0b",
                                 m_axis_tdata, m_axis_tlast, m_axis_tuser,
                                 exp_beat[9:2], exp_beat[1], exp_beat[0]);
                    end
                end
            end else if (m_axis_tvalid) begin
                stalled    = 1'b1;
                stall_beat = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int t;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        t = 0;
        forever begin
            @(posedge clk);
            #1;
            if (hs) break;
            t++;
            if (t > 500) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: byte %h not accepted, required acceptance within 500 cycles", b);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0 || m_axis_tvalid) begin
            miscompares++;
            $display("FAIL drain_%s: got %0d beats pending valid=%0b required 0 pending valid=0",
                     name, exp_q.size(), m_axis_tvalid);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        vectors++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00 || m_axis_tlast !== 1'b0 ||
            m_axis_tuser !== 1'b0 || s_axis_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: got valid=%b data=%h last=%b user=%b sready=%b required 0 00 0 0 1",
                     name, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, s_axis_tready);
        end
    endtask

    task automatic case1;
        exp_q.push_back(beat(8'h11, 1'b0, 1'b0));
        exp_q.push_back(beat(8'h22, 1'b0, 1'b0));
        exp_q.push_back(beat(8'h00, 1'b0, 1'b0));
        exp_q.push_back(beat(8'h33, 1'b1, 1'b0));
        send(8'h03); send(8'h11); send(8'h22); send(8'h02); send(8'h33); send(8'h00);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        case1();
        drain("case1");

`ifndef BOARDMAN_COBS_MAXLEN_EN
        send(8'hFF);
        for (int i = 1; i <= 254; i++) begin
            exp_q.push_back(beat(8'(i), (i == 254), 1'b0));
            send(8'(i));
        end
        send(8'h01);
        send(8'h00);
        drain("code_ff");
`endif

        exp_q.push_back(beat(8'hAA, 1'b1, 1'b1));
        send(8'h04); send(8'hAA); send(8'h00);
        exp_q.push_back(beat(8'h00, 1'b1, 1'b1));
        send(8'h05); send(8'h00);
        drain("truncated");

        send(8'h00);
        send(8'h01); send(8'h00);
        exp_q.push_back(beat(8'h5A, 1'b1, 1'b0));
        send(8'h02); send(8'h5A); send(8'h00);
        drain("empty_frames");

        rand_rdy = 1'b1;
        case1();
        case1();
        drain("random_ready");
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send(8'h03); send(8'h11);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_async");
        @(posedge clk);
        #1;
        check_idle_outputs("reset_edge");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(beat(8'h77, 1'b1, 1'b0));
        send(8'h02); send(8'h77); send(8'h00);
        drain("after_reset");

`ifdef BOARDMAN_COBS_MAXLEN_EN
        for (int i = 1; i <= 4; i++) exp_q.push_back(beat(8'(i), (i == 4), (i == 4)));
        send(8'h07);
        for (int i = 1; i <= 6; i++) send(8'(i));
        send(8'h00);
        drain("maxlen");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
